fp_mat_writeback: RTL and testbench

- Avalon-MM write master that streams a block of 32-bit words from the local matrix RAM back to SDRAM.
- It is the write-side counterpart of the determinant unit's SDRAM load path.
- The Nios starts it through a custom instruction (base address, word count).
- It reads the on-chip RAM through a two-entry prefetch buffer, writes each word to consecutive SDRAM addresses, and raises an interrupt on completion. The interrupt is cleared by an Avalon slave read.

---
 rtl/fp_mat_writeback.sv | 172 +++++++++++++++++
 tb/tb_fp_mat_writeback.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mat_writeback.sv
// Avalon-MM write master: streams words from local matrix RAM to consecutive SDRAM addresses.
// Optional FP_WB_CHECKSUM_EN adds a running XOR of accepted write data, readable at status word 1.
//
// state | meaning
// IDLE  | waiting for a custom-instruction start
// RUN   | fetching from RAM and writing to SDRAM
// DRAIN | all RAM reads issued, flushing remaining writes
// FIN   | transfer complete, irq held until a status read
module fp_mat_writeback #(
   parameter logic [10:0] DEFAULT_WORDS = 11'd256,
   parameter logic [10:0] MAX_WORDS     = 11'd1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic        done,
   output logic [31:0] result,
   output logic [23:0] address,
   output logic        write,
   output logic [31:0] writedata,
   input  logic        waitrequest,
   output logic [9:0]  ram_rdaddress,
   output logic        ram_rden,
   input  logic [31:0] ram_q,
   input  logic        status_read,
   input  logic        status_address,
   output logic [31:0] status_readdata,
   output logic        irq
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
   state_t state, state_nxt;

   logic [23:0] base;
   logic [10:0] n_words, fetch_cnt, wr_cnt, req_words, load_idx;
   logic [31:0] buf0, buf1, checksum_val;
   logic [1:0]  occ;
   logic        rd_inflight;
   logic        accept, wr_free, busy, load, push, pop, last_accept, start_ok;
   logic        unused_bits;

   assign unused_bits   = ^{dataa[31:24], dataa[1:0], datab[31:11]};
   assign req_words     = datab[10:0];
   assign ram_rdaddress = fetch_cnt[9:0];
   assign busy          = (state == RUN) || (state == DRAIN);
   assign start_ok      = start && (state == IDLE);
   assign accept        = write && !waitrequest;
   assign wr_free       = !write || accept;
   // The write register is refilled from the buffer head, or straight from ram_q when the buffer is empty.
   assign load          = busy && wr_free && ((occ != 2'd0) || rd_inflight);
   assign pop           = load && (occ != 2'd0);
   assign push          = rd_inflight && !(load && (occ == 2'd0));
   assign last_accept   = accept && (wr_cnt == n_words - 11'd1);
   assign load_idx      = wr_cnt + {10'd0, accept};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ram_rden  = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = RUN;
         RUN: begin
            // Reads in flight count against the buffer so a stalled write can never overflow it.
            ram_rden = (fetch_cnt < n_words) && ((occ + {1'b0, rd_inflight}) < 2'd2);
            if (fetch_cnt == n_words) state_nxt = DRAIN;
         end
         DRAIN: if (last_accept) state_nxt = FIN;
         FIN:   if (status_read) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base        <= '0;
         n_words     <= '0;
         fetch_cnt   <= '0;
         wr_cnt      <= '0;
         occ         <= '0;
         buf0        <= '0;
         buf1        <= '0;
         rd_inflight <= 1'b0;
         write       <= 1'b0;
         address     <= '0;
         writedata   <= '0;
      end else begin
         rd_inflight <= ram_rden;
         if (start_ok) begin
            base      <= {dataa[23:2], 2'b00};
            n_words   <= (req_words == 11'd0) ? DEFAULT_WORDS :
                         ((req_words > MAX_WORDS) ? MAX_WORDS : req_words);
            fetch_cnt <= '0;
            wr_cnt    <= '0;
            occ       <= '0;
         end else begin
            if (ram_rden) fetch_cnt <= fetch_cnt + 11'd1;
            if (accept)   wr_cnt    <= wr_cnt + 11'd1;
            case ({push, pop})
               2'b10: begin
                  if (occ == 2'd0) buf0 <= ram_q;
                  else             buf1 <= ram_q;
                  occ <= occ + 2'd1;
               end
               2'b01: begin
                  buf0 <= buf1;
                  occ  <= occ - 2'd1;
               end
               2'b11: begin
                  if (occ == 2'd2) begin
                     buf0 <= buf1;
                     buf1 <= ram_q;
                  end else begin
                     buf0 <= ram_q;
                  end
               end
               default: ;
            endcase
         end
         if (load) begin
            write     <= 1'b1;
            writedata <= (occ != 2'd0) ? buf0 : ram_q;
            address   <= base + {11'd0, load_idx, 2'b00};
         end else if (accept) begin
            write     <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done            <= 1'b0;
         result          <= '0;
         irq             <= 1'b0;
         status_readdata <= '0;
      end else begin
         if (start) begin
            done <= 1'b1;
            case (state)
               IDLE:    result <= 32'd0;
               FIN:     result <= 32'd3;
               default: result <= 32'd1;
            endcase
         end else begin
            done <= 1'b0;
            if (state == IDLE) result <= 32'd999;
         end
         if ((state == DRAIN) && last_accept)    irq <= 1'b1;
         else if ((state == FIN) && status_read) irq <= 1'b0;
         if (status_read)
            status_readdata <= status_address ? checksum_val : {busy, 20'd0, wr_cnt};
      end
   end

`ifdef FP_WB_CHECKSUM_EN
   logic [31:0] checksum;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      checksum <= '0;
      else if (start_ok) checksum <= '0;
      else if (accept)   checksum <= checksum ^ writedata;
   end
   assign checksum_val = checksum;
`else
   assign checksum_val = 32'h0;
`endif

endmodule

// File: tb/tb_fp_mat_writeback.sv
// Bench for fp_mat_writeback: RAM model, random waitrequest, queue-based model of expected SDRAM writes.
module tb_fp_mat_writeback;
   logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0;
   logic [31:0] dataa = '0, datab = '0;
   logic        done, write, ram_rden, irq;
   logic [31:0] result, writedata, status_readdata;
   logic [23:0] address;
   logic        waitrequest = 1'b0;
   logic [9:0]  ram_rdaddress;
   logic [31:0] ram_q = '0;
   logic        status_read = 1'b0, status_address = 1'b0;

   fp_mat_writeback dut (
      .clk(clk), .reset_n(reset_n), .start(start), .dataa(dataa), .datab(datab),
      .done(done), .result(result), .address(address), .write(write),
      .writedata(writedata), .waitrequest(waitrequest), .ram_rdaddress(ram_rdaddress),
      .ram_rden(ram_rden), .ram_q(ram_q), .status_read(status_read),
      .status_address(status_address), .status_readdata(status_readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   logic [31:0] ram [0:1023];
   always @(posedge clk) if (ram_rden) ram_q <= ram[ram_rdaddress];

   int n_checks = 0, n_errors = 0, cyc = 0;
   int stall_mode = 0, stall_left = 0, n_fetch = 0, n_acc = 0, done_cyc = 0;
   bit stall_done = 0, prev_stall = 0;
   logic [23:0] prev_addr;
   logic [31:0] prev_data, exp_csum;
   logic [23:0] exp_addr [$];
   logic [31:0] exp_data [$];
   logic [23:0] acc_addr [$];
   int          acc_cyc  [$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      if (!reset_n) begin
         prev_stall = 0;
         return;
      end
      if (prev_stall) begin
         check("hold_write", {31'd0, write}, 32'd1);
         check("hold_addr", {8'd0, address}, {8'd0, prev_addr});
         check("hold_data", writedata, prev_data);
      end
      if (ram_rden) begin
         check("rd_addr", {22'd0, ram_rdaddress}, 32'(n_fetch % 1024));
         n_fetch++;
      end
      check("in_dut_bound", {31'd0, (n_fetch - n_acc) <= 3}, 32'd1);
      if (write && !waitrequest) begin
         if (exp_addr.size() == 0) begin
            check("extra_write", {8'd0, address}, 32'hFFFFFFFF);
         end else begin
            check("wr_addr", {8'd0, address}, {8'd0, exp_addr[0]});
            check("wr_data", writedata, exp_data[0]);
            void'(exp_addr.pop_front());
            void'(exp_data.pop_front());
         end
         n_acc++;
         acc_addr.push_back(address);
         acc_cyc.push_back(cyc);
      end
      prev_stall = write && waitrequest;
      prev_addr  = address;
      prev_data  = writedata;
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (stall_left > 0) begin
         waitrequest = 1'b1;
         stall_left--;
      end else if (stall_mode == 2 && write && n_acc == 1 && !stall_done) begin
         waitrequest = 1'b1;
         stall_left  = 2;
         stall_done  = 1;
      end else if (stall_mode == 1) begin
         waitrequest = ($urandom_range(0, 99) < 30);
      end else begin
         waitrequest = 1'b0;
      end
      monitor();
   endtask

   task automatic do_start(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res);
      logic [23:0] base;
      int n;
      if (exp_res == 0) begin
         base = {a[23:2], 2'b00};
         n = (b[10:0] == 0) ? 256 : ((b[10:0] > 1024) ? 1024 : int'(b[10:0]));
         exp_addr.delete(); exp_data.delete(); acc_addr.delete(); acc_cyc.delete();
         exp_csum = '0;
         for (int k = 0; k < n; k++) begin
            exp_addr.push_back(base + 24'(4 * k));
            exp_data.push_back(ram[k]);
            exp_csum ^= ram[k];
         end
         n_fetch = 0; n_acc = 0; stall_done = 0;
      end
      start = 1'b1; dataa = a; datab = b;
      tick();
      check("done_pulse", {31'd0, done}, 32'd1);
      check("start_result", result, exp_res);
      done_cyc = cyc;
      start = 1'b0;
      tick();
      check("done_single", {31'd0, done}, 32'd0);
   endtask

   task automatic do_status(input logic a, input logic [31:0] exp, input string nm);
      status_read = 1'b1; status_address = a;
      tick();
      status_read = 1'b0;
      check(nm, status_readdata, exp);
   endtask

   task automatic finish_xfer(input int n, input logic [31:0] exp_st0);
      int i = 0;
      while (!irq && i < 8 * n + 60) begin
         tick();
         i++;
      end
      check("irq_set", {31'd0, irq}, 32'd1);
      check("n_writes", 32'(n_acc), 32'(n));
      check("no_word_lost", 32'(exp_addr.size()), 32'd0);
      check("n_fetches", 32'(n_fetch), 32'(n));
      do_status(1'b0, exp_st0, "status_count");
      check("irq_cleared", {31'd0, irq}, 32'd0);
`ifdef FP_WB_CHECKSUM_EN
      do_status(1'b1, exp_csum, "status_csum");
`else
      do_status(1'b1, 32'h0, "status_csum");
`endif
   endtask

   initial begin
      logic [31:0] a;
      int n, i;
      for (int k = 0; k < 1024; k++) ram[k] = $urandom;
      repeat (2) tick();
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_address", {8'd0, address}, 32'd0);
      check("rst_write", {31'd0, write}, 32'd0);
      check("rst_wdata", writedata, 32'd0);
      check("rst_rdaddr", {22'd0, ram_rdaddress}, 32'd0);
      check("rst_rden", {31'd0, ram_rden}, 32'd0);
      check("rst_status", status_readdata, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      reset_n = 1'b1;
      tick();
      check("idle_result", result, 32'd999);

      // basic 4-word transfer, no stalls
      for (int k = 0; k < 4; k++) ram[k] = 32'hA000_0000 + 32'(k);
      stall_mode = 0;
      do_start(32'h0000_0100, 32'd4, 32'd0);
      finish_xfer(4, 32'h0000_0004);
      check("t1_first_lat", 32'(acc_cyc[0]), 32'(done_cyc + 2));
      check("t1_back2back", 32'(acc_cyc[3]), 32'(acc_cyc[0] + 3));
      check("t1_addr0", {8'd0, acc_addr[0]}, 32'h100);
      check("t1_addr3", {8'd0, acc_addr[3]}, 32'h10C);
      tick();
      check("idle_result2", result, 32'd999);

      // same transfer with a 3-cycle stall on the second write
      stall_mode = 2;
      do_start(32'h0000_0100, 32'd4, 32'd0);
      finish_xfer(4, 32'h0000_0004);
      check("t2_addr1", {8'd0, acc_addr[1]}, 32'h104);
      check("t2_stall_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);

      // default count and clamped count under random stalls
      stall_mode = 1;
      do_start(32'h0001_2340, 32'd0, 32'd0);
      finish_xfer(256, 32'h0000_0100);
      check("t3_last_addr", {8'd0, acc_addr[255]}, 32'h0001_273C);
      do_start(32'h0020_0000, 32'd2000, 32'd0);
      finish_xfer(1024, 32'h0000_0400);

      // 24-bit address wrap
      do_start(32'h00FF_FFF8, 32'd4, 32'd0);
      finish_xfer(4, 32'h0000_0004);
      check("wrap_a0", {8'd0, acc_addr[0]}, 32'hFF_FFF8);
      check("wrap_a1", {8'd0, acc_addr[1]}, 32'hFF_FFFC);
      check("wrap_a2", {8'd0, acc_addr[2]}, 32'h00_0000);
      check("wrap_a3", {8'd0, acc_addr[3]}, 32'h00_0004);

      // rejected starts in RUN and FIN, then start+status_read together in FIN
      do_start(32'h0000_0400, 32'd16, 32'd0);
      tick();
      do_start(32'h0000_0000, 32'd3, 32'd1);
      i = 0;
      while (!irq && i < 300) begin tick(); i++; end
      check("t5_irq", {31'd0, irq}, 32'd1);
      check("t5_n_writes", 32'(n_acc), 32'd16);
      do_start(32'h0000_0000, 32'd3, 32'd3);
      check("t5_irq_kept", {31'd0, irq}, 32'd1);
      start = 1'b1; status_read = 1'b1; status_address = 1'b0;
      tick();
      start = 1'b0; status_read = 1'b0;
      check("fin_both_done", {31'd0, done}, 32'd1);
      check("fin_both_result", result, 32'd3);
      check("fin_both_status", status_readdata, 32'h0000_0010);
      check("fin_both_irq", {31'd0, irq}, 32'd0);
      tick();
      check("fin_both_single", {31'd0, done}, 32'd0);
      check("t5_no_extra", 32'(n_acc), 32'd16);

      // reset during write 5 of 16
      stall_mode = 0;
      do_start(32'h0000_0800, 32'd16, 32'd0);
      i = 0;
      while (n_acc < 5 && i < 100) begin tick(); i++; end
      check("t6_reached_w5", 32'(n_acc), 32'd5);
      reset_n = 1'b0;
      #1;
      check("t6_write_drop", {31'd0, write}, 32'd0);
      check("t6_irq_low", {31'd0, irq}, 32'd0);
      exp_addr.delete(); exp_data.delete();
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      ram[0] = 32'h1234_5678;
      ram[1] = 32'h0F0F_00FF;
      do_start(32'h0000_0000, 32'd2, 32'd0);
      finish_xfer(2, 32'h0000_0002);
      status_read = 1'b1; status_address = 1'b1;
      tick();
      status_read = 1'b0;
`ifdef FP_WB_CHECKSUM_EN
      check("t6_csum", status_readdata, 32'h1D3B_5687);
`else
      check("t6_csum", status_readdata, 32'h0);
`endif

      // randomized transfers
      stall_mode = 1;
      for (int t = 0; t < 6; t++) begin
         for (int k = 0; k < 64; k++) ram[k] = $urandom;
         a = $urandom;
         n = $urandom_range(1, 40);
         do_start(a, 32'(n), 32'd0);
         finish_xfer(n, 32'(n));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
